// File: rtl/bowling_sequencer.sv
// bowling_sequencer: paces AI deliveries, pulses ai_en once per ball and tallies balls, overs, wickets and extras.
// Optional NO_BALL_EN macro honours no_ball: counts extras and re-bowls the delivery.
module bowling_sequencer #(
  parameter int BALLS_PER_OVER = 6,
  parameter int NUM_OVERS      = 2,
  parameter int MAX_WICKETS    = 10,
  parameter int GAP_CYCLES     = 50_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int CNT_W          = 28
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       ball_done,
  input  logic       wicket,
  input  logic       no_ball,
  output logic       ai_en,
  output logic [2:0] ball_cnt,
  output logic [3:0] over_cnt,
  output logic [3:0] wickets,
  output logic [3:0] extras,
  output logic       timeout,
  output logic       busy,
  output logic       innings_over
);
  if (BALLS_PER_OVER < 1 || BALLS_PER_OVER > 7 || NUM_OVERS < 1 || NUM_OVERS > 15 ||
      MAX_WICKETS < 1 || MAX_WICKETS > 15 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1 || CNT_W < 1 ||
      ((GAP_CYCLES - 1) >> CNT_W) != 0 || ((TIMEOUT_CYCLES - 1) >> CNT_W) != 0) begin : g_param_check
    $error("bowling_sequencer: parameter out of range");
  end
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_BALL = 3'(BALLS_PER_OVER - 1);
  localparam logic [3:0]       OVERS     = 4'(NUM_OVERS);
  localparam logic [3:0]       WKTS      = 4'(MAX_WICKETS);
  typedef enum logic [2:0] {IDLE, GAP, ARM, FLIGHT, TALLY, DONE} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wk_q, wk_d, nb_q, nb_d;
  logic [2:0]       ball_q, ball_d;
  logic [3:0]       over_q, over_d, wkt_q, wkt_d, ext_q, ext_d;
  logic             ai_en_q, busy_q, done_q;
  logic             nb_in;
`ifdef NO_BALL_EN
  assign nb_in = no_ball;
`else
  logic unused_no_ball;
  assign nb_in = 1'b0;
  assign unused_no_ball = no_ball;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wk_d    = wk_q;
    nb_d    = nb_q;
    ball_d  = ball_q;
    over_d  = over_q;
    wkt_d   = wkt_q;
    ext_d   = ext_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = start ? GAP : IDLE;
        cnt_d   = start ? GAP_LD : cnt_q;
      end
      GAP: begin
        state_d = cnt_q == '0 ? ARM : GAP;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      ARM: begin
        state_d = FLIGHT;
        cnt_d   = TO_LD;
      end
      FLIGHT: begin
        // a resolution arriving on the expiry cycle beats the forced dot ball
        timeout = !ball_done && cnt_q == '0;
        state_d = ball_done || cnt_q == '0 ? TALLY : FLIGHT;
        cnt_d   = ball_done || cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        wk_d    = ball_done & wicket;
        nb_d    = ball_done & nb_in;
      end
      TALLY: begin
        ext_d   = nb_q && ext_q != 4'hF ? ext_q + 4'd1 : ext_q;
        wkt_d   = nb_q ? wkt_q : wkt_q + {3'b000, wk_q};
        ball_d  = nb_q ? ball_q : (ball_q == LAST_BALL ? 3'd0 : ball_q + 3'd1);
        over_d  = !nb_q && ball_q == LAST_BALL ? over_q + 4'd1 : over_q;
        state_d = wkt_d == WKTS || over_d == OVERS ? DONE : GAP;
        cnt_d   = GAP_LD;
      end
      DONE: begin
        state_d = start ? GAP : DONE;
        cnt_d   = start ? GAP_LD : cnt_q;
        ball_d  = start ? 3'd0 : ball_q;
        over_d  = start ? 4'd0 : over_q;
        wkt_d   = start ? 4'd0 : wkt_q;
        ext_d   = start ? 4'd0 : ext_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wk_q    <= 1'b0;
      nb_q    <= 1'b0;
      ball_q  <= '0;
      over_q  <= '0;
      wkt_q   <= '0;
      ext_q   <= '0;
      ai_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wk_q    <= wk_d;
      nb_q    <= nb_d;
      ball_q  <= ball_d;
      over_q  <= over_d;
      wkt_q   <= wkt_d;
      ext_q   <= ext_d;
      ai_en_q <= state_d == ARM;
      busy_q  <= state_d inside {GAP, ARM, FLIGHT, TALLY};
      done_q  <= state_d == DONE;
    end
  end
  assign ai_en        = ai_en_q;
  assign ball_cnt     = ball_q;
  assign over_cnt     = over_q;
  assign wickets      = wkt_q;
  assign extras       = ext_q;
  assign busy         = busy_q;
  assign innings_over = done_q;
endmodule
